// File: rtl/packet_sink_pkg.sv
// ----------------------------------------------------------------------------
// packet_sink_pkg
//   Shared definitions for the flit link receive endpoint: flit type codes,
//   flit field offsets and the receiver FSM state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package packet_sink_pkg;

    typedef enum logic [1:0] {
        FLIT_EMPTY = 2'b00,
        FLIT_HEAD  = 2'b01,
        FLIT_BODY  = 2'b10,
        FLIT_TAIL  = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam int FLIT_TYPE_W   = 2;
    localparam int FLIT_DATA_LSB = 0;

    // The type field sits directly above the data field.
    function automatic int flit_type_lsb(input int data_size);
        return data_size;
    endfunction

endpackage

// File: rtl/packet_sink_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk    in   clock, rising edge
//     a_rst  in   asynchronous reset, active-low (clears the count)
//     inc_i  in   increment request for this cycle
//     cnt_o  out  current count (CNT_W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/packet_sink.sv
// ----------------------------------------------------------------------------
// packet_sink
//   Receive-side endpoint of the flit link. Accepts flits over the
//   wr_ready_in/r_ready_out handshake, reassembles packets, checks framing,
//   destination, length and checksum, and counts good and bad packets.
//   Ports:
//     clk          in   clock, rising edge
//     a_rst        in   asynchronous reset, active-low
//     data_i       in   flit: [DATA_SIZE+1:DATA_SIZE]=type, [DATA_SIZE-1:0]=data
//     wr_ready_in  in   sender has a valid flit on data_i
//     r_ready_out  out  sink can accept a flit this cycle
//     pkt_cnt_o    out  good packets received (saturating)
//     err_cnt_o    out  bad packets / framing errors (saturating)
//     last_src_o   out  source address of last good packet
//     err_o        out  one-cycle pulse per detected error
//     done_o       out  sticky, set once PACKS_TO_RECV good packets arrived
// ----------------------------------------------------------------------------
module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_SIZE     = 1,
    parameter int ADDR          = 0,
    parameter int MAX_PACK_LEN  = 10,
    parameter int PACKS_TO_RECV = 10,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [DATA_SIZE+1:0] data_i,
    input  logic                 wr_ready_in,
    output logic                 r_ready_out,
    output logic [CNT_W-1:0]     pkt_cnt_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [ADDR_SIZE-1:0] last_src_o,
    output logic                 err_o,
    output logic                 done_o
);

    localparam int TYPE_LSB = flit_type_lsb(DATA_SIZE);
    // One spare bit so the length can sit at MAX_PACK_LEN+1 to mark overflow.
    localparam int LEN_W    = $clog2(MAX_PACK_LEN + 1) + 1;
    localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(MAX_PACK_LEN);
    localparam logic [LEN_W-1:0]     MAX_BODY  = LEN_W'(MAX_PACK_LEN - 1);
    localparam logic [CNT_W-1:0]     DONE_PREV = CNT_W'(PACKS_TO_RECV - 1);
    localparam logic [ADDR_SIZE-1:0] MY_ADDR   = ADDR_SIZE'(ADDR);

    state_e                 state_q, state_d;
    logic                   r_ready_q, r_ready_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [ADDR_SIZE-1:0]   last_src_q, last_src_d;
    logic [ADDR_SIZE-1:0]   src_q, src_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [DATA_SIZE-1:0]   csum_q, csum_d;
    logic                   bad_q, bad_d;

    logic                   xfer;
    flit_type_e             ftype;
    logic [DATA_SIZE-1:0]   fdata;
    logic [ADDR_SIZE-1:0]   hd_dst;
    logic [ADDR_SIZE-1:0]   hd_src;
    logic [LEN_W-1:0]       len_nx;
    logic                   pkt_inc;

    assign xfer   = wr_ready_in && r_ready_q;
    assign ftype  = flit_type_e'(data_i[TYPE_LSB +: FLIT_TYPE_W]);
    assign fdata  = data_i[FLIT_DATA_LSB +: DATA_SIZE];
    assign hd_dst = fdata[ADDR_SIZE-1:0];
    assign hd_src = fdata[2*ADDR_SIZE-1:ADDR_SIZE];
    assign len_nx = (len_q > MAX_LEN) ? len_q : len_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        len_d      = len_q;
        csum_d     = csum_q;
        bad_d      = bad_q;
        last_src_d = last_src_q;
        err_d      = 1'b0;
        pkt_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (ftype == FLIT_HEAD) begin
                        src_d   = hd_src;
                        len_d   = LEN_W'(1);
                        csum_d  = '0;
                        bad_d   = (hd_dst != MY_ADDR);
                        state_d = ST_RECV;
                    end else if (ftype != FLIT_EMPTY) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (xfer) begin
                    case (ftype)
                        FLIT_HEAD: begin
                            // Abandon the open packet (one error) and restart.
                            err_d  = 1'b1;
                            src_d  = hd_src;
                            len_d  = LEN_W'(1);
                            csum_d = '0;
                            bad_d  = (hd_dst != MY_ADDR);
                        end
                        FLIT_BODY: begin
                            len_d  = len_nx;
                            csum_d = csum_q ^ fdata;
                            // A body flit must leave room for the tail.
                            if (len_nx > MAX_BODY) begin
                                bad_d = 1'b1;
                            end
                        end
                        FLIT_TAIL: begin
                            len_d = len_nx;
                            if (!bad_q && (len_nx <= MAX_LEN) && (fdata == csum_q)) begin
                                pkt_inc    = 1'b1;
                                last_src_d = src_q;
                            end else begin
                                err_d = 1'b1;
                            end
                            state_d = ST_DRAIN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        r_ready_d = (state_d != ST_DRAIN);
        done_d    = done_q || (pkt_inc && (pkt_cnt_o >= DONE_PREV));
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= ST_IDLE;
            r_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            last_src_q <= '0;
        end else begin
            state_q    <= state_d;
            r_ready_q  <= r_ready_d;
            err_q      <= err_d;
            done_q     <= done_d;
            last_src_q <= last_src_d;
        end
    end

    // Per-packet working registers; only meaningful once a HEAD loads them.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        len_q  <= len_d;
        csum_q <= csum_d;
        bad_q  <= bad_d;
    end

    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .inc_i (pkt_inc),
        .cnt_o (pkt_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .inc_i (err_d),
        .cnt_o (err_cnt_o)
    );

    assign r_ready_out = r_ready_q;
    assign err_o       = err_q;
    assign done_o      = done_q;
    assign last_src_o  = last_src_q;

endmodule

// File: tb/tb_packet_sink.sv
module tb_packet_sink;

    localparam logic [1:0] T_EMPTY = 2'b00;
    localparam logic [1:0] T_HEAD  = 2'b01;
    localparam logic [1:0] T_BODY  = 2'b10;
    localparam logic [1:0] T_TAIL  = 2'b11;

    logic       clk = 1'b0;
    logic       a_rst = 1'b0;
    logic [5:0] data_i = '0;
    logic       wr_ready_in = 1'b0;
    logic       r_ready_out;
    logic [7:0] pkt_cnt_o;
    logic [7:0] err_cnt_o;
    logic [0:0] last_src_o;
    logic       err_o;
    logic       done_o;

    packet_sink #(
        .DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(0),
        .MAX_PACK_LEN(10), .PACKS_TO_RECV(10), .CNT_W(8)
    ) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .data_i      (data_i),
        .wr_ready_in (wr_ready_in),
        .r_ready_out (r_ready_out),
        .pkt_cnt_o   (pkt_cnt_o),
        .err_cnt_o   (err_cnt_o),
        .last_src_o  (last_src_o),
        .err_o       (err_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_pkt = 0;
    int exp_err = 0;

    typedef struct packed {
        logic is_err;
        logic src;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic       src;
        logic       dst;
        int         nbody;
        logic [3:0] seed;
        logic [3:0] flip;
        logic       good;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic is_err, input logic src);
        exp_q.push_back('{is_err: is_err, src: src});
        if (is_err) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        else        exp_pkt = exp_pkt + 1;
    endtask

    // Scoreboard: every err_o cycle or pkt_cnt step must match the next queued event.
    logic [7:0] prev_pkt = '0;
    task automatic pop_ev(input logic is_err, input logic src);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got_err=%b got_src=%b want=none", is_err, src);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err != is_err || (!is_err && e.src != src)) begin
                bad++;
                $display("FAIL event got_err=%b got_src=%b want_err=%b want_src=%b",
                         is_err, src, e.is_err, e.src);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!a_rst) begin
            prev_pkt = '0;
        end else begin
            if (err_o) pop_ev(1'b1, 1'b0);
            if (pkt_cnt_o != prev_pkt) begin
                pop_ev(1'b0, last_src_o[0]);
                prev_pkt = pkt_cnt_o;
            end
        end
    end

    // Offer one flit and hold it until the sink takes it (bounded wait).
    task automatic send_flit(input logic [1:0] t, input logic [3:0] d);
        int waited = 0;
        data_i = {t, d};
        wr_ready_in = 1'b1;
        while (r_ready_out !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (r_ready_out !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout ready=%b want=1", r_ready_out);
        end else begin
            @(posedge clk); #1;
        end
        wr_ready_in = 1'b0;
    endtask

    task automatic idle_gap(input bit en);
        if (en) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 1) == 1) send_flit(T_EMPTY, 4'hF);
        end
    endtask

    task automatic send_pkt(input logic src, input logic dst, input int nbody,
                            input logic [3:0] seed, input logic [3:0] flip,
                            input logic good, input bit gaps);
        logic [3:0] csum = 4'h0;
        logic [3:0] b;
        send_flit(T_HEAD, {2'b00, src, dst});
        for (int i = 0; i < nbody; i++) begin
            idle_gap(gaps);
            b = seed + 4'(i);
            csum = csum ^ b;
            send_flit(T_BODY, b);
        end
        idle_gap(gaps);
        push_ev(!good, src);
        send_flit(T_TAIL, csum ^ flip);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 2, 4'h3, 4'h0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2, 4'h3, 4'h1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1, 4'h9, 4'h0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8, 4'hA, 4'h0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 9, 4'h1, 4'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 0, 4'h0, 4'h2, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5, 4'hF, 4'h0, 1'b1};

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_ready", r_ready_out, 0);
        chk("rst_pkt_cnt", pkt_cnt_o, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("rst_last_src", last_src_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_done", done_o, 0);
        a_rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", r_ready_out, 1);

        // Good packet: HEAD(src1,dst0), BODY 3, BODY 5, TAIL 6
        send_flit(T_HEAD, 4'h2);
        send_flit(T_BODY, 4'h3);
        send_flit(T_BODY, 4'h5);
        push_ev(1'b0, 1'b1);
        send_flit(T_TAIL, 4'h6);
        chk("drain_ready_low", r_ready_out, 0);
        chk("good_pkt_cnt", pkt_cnt_o, 1);
        chk("good_last_src", last_src_o, 1);
        chk("good_err_cnt", err_cnt_o, 0);
        @(posedge clk); #1;
        chk("drain_ready_back", r_ready_out, 1);

        // Bad checksum
        send_flit(T_HEAD, 4'h2);
        send_flit(T_BODY, 4'h3);
        send_flit(T_BODY, 4'h5);
        push_ev(1'b1, 1'b0);
        send_flit(T_TAIL, 4'h7);
        chk("csum_err_cnt", err_cnt_o, 2'd1);
        chk("csum_pkt_cnt", pkt_cnt_o, 1);

        // Framing: BODY in IDLE, then HEAD BODY HEAD TAIL(0)
        push_ev(1'b1, 1'b0);
        send_flit(T_BODY, 4'h1);
        chk("frame_idle_err_cnt", err_cnt_o, 2);
        send_flit(T_HEAD, 4'h2);
        send_flit(T_BODY, 4'h4);
        push_ev(1'b1, 1'b0);
        send_flit(T_HEAD, 4'h2);
        push_ev(1'b0, 1'b1);
        send_flit(T_TAIL, 4'h0);
        chk("frame_head_err_cnt", err_cnt_o, 3);
        chk("frame_head_pkt_cnt", pkt_cnt_o, 2);

        // Table of packets: checksum, length and address corners
        for (int v = 0; v < 8; v++) begin
            send_pkt(vecs[v].src, vecs[v].dst, vecs[v].nbody, vecs[v].seed,
                     vecs[v].flip, vecs[v].good, 1'b0);
            chk($sformatf("vec%0d_pkt_cnt", v), pkt_cnt_o, exp_pkt);
            chk($sformatf("vec%0d_err_cnt", v), err_cnt_o, exp_err);
        end

        // Done with backpressure and EMPTY flits, back-to-back into DRAIN
        while (exp_pkt < 11) begin
            send_pkt(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 4),
                     4'($urandom_range(0, 15)), 4'h0, 1'b1, 1'b1);
            chk($sformatf("done_at_%0d", exp_pkt), done_o, (exp_pkt >= 10) ? 1 : 0);
            chk($sformatf("pkt_cnt_at_%0d", exp_pkt), pkt_cnt_o, exp_pkt);
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            push_ev(1'b1, 1'b0);
            send_flit(T_BODY, 4'h8);
        end
        chk("err_cnt_saturated", err_cnt_o, 255);
        chk("pkt_cnt_after_sat", pkt_cnt_o, exp_pkt);

        // Reset mid-packet
        send_flit(T_HEAD, 4'h2);
        send_flit(T_BODY, 4'h3);
        a_rst = 1'b0;
        #2;
        chk("midrst_pkt_cnt", pkt_cnt_o, 0);
        chk("midrst_err_cnt", err_cnt_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_err_o", err_o, 0);
        chk("midrst_r_ready", r_ready_out, 0);
        chk("midrst_last_src", last_src_o, 0);
        exp_pkt = 0;
        exp_err = 0;
        @(posedge clk); #1;
        a_rst = 1'b1;
        @(posedge clk); #1;
        send_pkt(1'b0, 1'b0, 2, 4'h6, 4'h0, 1'b1, 1'b0);
        chk("post_rst_pkt_cnt", pkt_cnt_o, 1);
        chk("post_rst_err_cnt", err_cnt_o, 0);
        chk("post_rst_done", done_o, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
